// File: rtl/outgoing_port_arbiter.sv
// Output port arbiter: round-robin selection among the incoming port
// handlers that target this port, followed by a small header FIFO that
// feeds the downstream link through a valid/ready handshake.
module outgoing_port_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int REQ_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            requestIn,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] destinationAddressIn,
  input  logic [NUM_INPUTS*REQ_WIDTH-1:0]  requesterAddressIn,
  input  logic [NUM_INPUTS-1:0]            readIn,
  input  logic [NUM_INPUTS-1:0]            writeIn,
  output logic [NUM_INPUTS-1:0]            grantOut,
  output logic                             validOut,
  input  logic                             readyIn,
  output logic [ADDR_WIDTH-1:0]            destinationAddressOut,
  output logic [REQ_WIDTH-1:0]             requesterAddressOut,
  output logic                             readOut,
  output logic                             writeOut,
  output logic [$clog2(FIFO_DEPTH):0]      fifoCount
);

  localparam int RR_W  = $clog2(NUM_INPUTS);
  localparam int SUM_W = RR_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] NUM_SUM    = SUM_W'(NUM_INPUTS);
  localparam logic [RR_W-1:0]  LAST_INPUT = RR_W'(NUM_INPUTS - 1);

  logic [RR_W-1:0]  rrPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  logic [ADDR_WIDTH-1:0] addrMem  [FIFO_DEPTH];
  logic [REQ_WIDTH-1:0]  reqMem   [FIFO_DEPTH];
  logic                  readMem  [FIFO_DEPTH];
  logic                  writeMem [FIFO_DEPTH];

  logic             found;
  logic [RR_W-1:0]  winner;
  logic [SUM_W-1:0] scanSum;
  logic [RR_W-1:0]  scanIdx;
  logic             push;
  logic             pop;

  logic [ADDR_WIDTH-1:0] selAddr;
  logic [REQ_WIDTH-1:0]  selReq;
  logic                  selRead;
  logic                  selWrite;

  // Scan requesters starting at rrPtr and wrapping; the first set bit wins.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scanSum = '0;
    scanIdx = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scanSum = {1'b0, rrPtr} + SUM_W'(k);
      if (scanSum >= NUM_SUM) begin
        scanSum = scanSum - NUM_SUM;
      end
      scanIdx = scanSum[RR_W-1:0];
      if (!found && requestIn[scanIdx]) begin
        found  = 1'b1;
        winner = scanIdx;
      end
    end
  end

  // A push needs a requester, a free slot (no pass-through when full) and no reset.
  always_comb begin
    push = found && (count < FULL_COUNT) && !reset;
    pop  = validOut && readyIn;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      grantOut[i] = push && (winner == RR_W'(i));
    end
  end

  // Route the winning handler's header fields toward the FIFO write port.
  always_comb begin
    selAddr  = '0;
    selReq   = '0;
    selRead  = 1'b0;
    selWrite = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (winner == RR_W'(i)) begin
        selAddr  = destinationAddressIn[i*ADDR_WIDTH +: ADDR_WIDTH];
        selReq   = requesterAddressIn[i*REQ_WIDTH +: REQ_WIDTH];
        selRead  = readIn[i];
        selWrite = writeIn[i];
      end
    end
  end

  // Present the FIFO head; outputs are zeroed whenever the FIFO is empty.
  always_comb begin
    validOut              = (count != '0);
    fifoCount             = count;
    destinationAddressOut = '0;
    requesterAddressOut   = '0;
    readOut               = 1'b0;
    writeOut              = 1'b0;
    if (validOut) begin
      destinationAddressOut = addrMem[rdPtr];
      requesterAddressOut   = reqMem[rdPtr];
      readOut               = readMem[rdPtr];
      writeOut              = writeMem[rdPtr];
    end
  end

  // Pointer, count and storage updates; reset wins over any push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addrMem[i]  <= '0;
        reqMem[i]   <= '0;
        readMem[i]  <= 1'b0;
        writeMem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        addrMem[wrPtr]  <= selAddr;
        reqMem[wrPtr]   <= selReq;
        readMem[wrPtr]  <= selRead;
        writeMem[wrPtr] <= selWrite;
        wrPtr           <= wrPtr + 1'b1;
        rrPtr           <= (winner == LAST_INPUT) ? '0 : winner + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_outgoing_port_arbiter.sv
// Self-checking bench for outgoing_port_arbiter: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_outgoing_port_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int RW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  requestIn;
  logic [N*AW-1:0] destinationAddressIn;
  logic [N*RW-1:0] requesterAddressIn;
  logic [N-1:0]  readIn;
  logic [N-1:0]  writeIn;
  logic [N-1:0]  grantOut;
  logic          validOut;
  logic          readyIn;
  logic [AW-1:0] destinationAddressOut;
  logic [RW-1:0] requesterAddressOut;
  logic          readOut;
  logic          writeOut;
  logic [2:0]    fifoCount;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] req;
    logic          rd;
    logic          wr;
  } hdr_t;

  hdr_t modelQ[$];
  int   modelRr;
  int   passCount  = 0;
  int   checkCount = 0;

  logic [N-1:0]  obsGrant;
  logic          obsValid;
  logic [AW-1:0] obsDest;
  logic [RW-1:0] obsReq;
  logic          obsRd;
  logic          obsWr;
  logic [2:0]    obsCount;

  outgoing_port_arbiter #(
    .NUM_INPUTS(N),
    .FIFO_DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .REQ_WIDTH(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .requestIn(requestIn),
    .destinationAddressIn(destinationAddressIn),
    .requesterAddressIn(requesterAddressIn),
    .readIn(readIn),
    .writeIn(writeIn),
    .grantOut(grantOut),
    .validOut(validOut),
    .readyIn(readyIn),
    .destinationAddressOut(destinationAddressOut),
    .requesterAddressOut(requesterAddressOut),
    .readOut(readOut),
    .writeOut(writeOut),
    .fifoCount(fifoCount)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Which handler the rules say should win this cycle, or -1 for none.
  function automatic int modelWinner();
    if (reset) return -1;
    if (modelQ.size() >= DEPTH) return -1;
    for (int k = 0; k < N; k++) begin
      if (requestIn[(modelRr + k) % N]) return (modelRr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    int   w;
    hdr_t head;
    logic [N-1:0] expGrant;
    w = modelWinner();
    expGrant = '0;
    if (w >= 0) expGrant[w] = 1'b1;
    head = '{addr: '0, req: '0, rd: 1'b0, wr: 1'b0};
    if (modelQ.size() > 0) head = modelQ[0];
    obsGrant = grantOut;
    obsValid = validOut;
    obsDest  = destinationAddressOut;
    obsReq   = requesterAddressOut;
    obsRd    = readOut;
    obsWr    = writeOut;
    obsCount = fifoCount;
    checkVal("model.grant", obsGrant, expGrant);
    checkVal("model.valid", obsValid, modelQ.size() > 0);
    checkVal("model.dest", obsDest, head.addr);
    checkVal("model.requester", obsReq, head.req);
    checkVal("model.read", obsRd, head.rd);
    checkVal("model.write", obsWr, head.wr);
    checkVal("model.count", obsCount, modelQ.size());
  endtask

  task automatic modelAdvance();
    int   w;
    hdr_t h;
    if (reset) begin
      modelQ.delete();
      modelRr = 0;
    end else begin
      w = modelWinner();
      if (modelQ.size() > 0 && readyIn) void'(modelQ.pop_front());
      if (w >= 0) begin
        h.addr = destinationAddressIn[w*AW +: AW];
        h.req  = requesterAddressIn[w*RW +: RW];
        h.rd   = readIn[w];
        h.wr   = writeIn[w];
        modelQ.push_back(h);
        modelRr = (w + 1) % N;
      end
    end
  endtask

  // Inputs are set at the falling edge; check mid-cycle, then cross the rising edge.
  task automatic stepCycle();
    #1;
    checkOutput();
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] rq, input logic rdy);
    reset     = rst;
    requestIn = rq;
    readyIn   = rdy;
  endtask

  task automatic setFields(input int i, input logic [AW-1:0] a, input logic [RW-1:0] r,
                           input logic rd, input logic wr);
    destinationAddressIn[i*AW +: AW] = a;
    requesterAddressIn[i*RW +: RW]   = r;
    readIn[i]  = rd;
    writeIn[i] = wr;
  endtask

  task automatic clearFields();
    destinationAddressIn = '0;
    requesterAddressIn   = '0;
    readIn  = '0;
    writeIn = '0;
  endtask

  task automatic randomFields();
    for (int i = 0; i < N; i++) begin
      setFields(i, AW'($urandom), RW'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, '0, 1'b0);
    stepCycle();
  endtask

  // Directed scenarios first, then randomized traffic with occasional resets.
  initial begin
    clearFields();
    applyStimulus(1'b1, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    modelRr = 0;

    // Reset state, with requests present while reset is held.
    applyStimulus(1'b1, 4'b1111, 1'b1);
    stepCycle();
    checkVal("reset.grant", obsGrant, 0);
    checkVal("reset.valid", obsValid, 0);
    checkVal("reset.count", obsCount, 0);
    checkVal("reset.dest", obsDest, 0);

    // Single request and one-cycle latency.
    applyStimulus(1'b0, 4'b0001, 1'b1);
    setFields(0, 12'h3A5, 4'h2, 1'b1, 1'b0);
    stepCycle();
    checkVal("single.grant", obsGrant, 4'b0001);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    clearFields();
    stepCycle();
    checkVal("single.valid", obsValid, 1);
    checkVal("single.dest", obsDest, 12'h3A5);
    checkVal("single.requester", obsReq, 4'h2);
    checkVal("single.read", obsRd, 1);
    checkVal("single.write", obsWr, 0);
    stepCycle();
    checkVal("single.drained", obsValid, 0);

    // Round-robin fairness with all handlers requesting.
    resetCycle();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      randomFields();
      stepCycle();
      checkVal("rr.grant", obsGrant, 32'(1) << (i % 4));
    end

    // Fill to full, stall grants, then drain in order.
    resetCycle();
    clearFields();
    applyStimulus(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      setFields(2, AW'(12'h100 + i), RW'(i), 1'b0, 1'b1);
      stepCycle();
      checkVal("fill.grant", obsGrant, (i < 4) ? 4'b0100 : 4'b0000);
      checkVal("fill.count", obsCount, (i < 4) ? i : 4);
    end
    applyStimulus(1'b0, 4'b0100, 1'b1);
    setFields(2, 12'h1FF, 4'hF, 1'b1, 1'b1);
    stepCycle();
    checkVal("full.noPassThrough", obsGrant, 4'b0000);
    checkVal("full.head0", obsDest, 12'h100);
    stepCycle();
    checkVal("full.resume", obsGrant, 4'b0100);
    checkVal("full.head1", obsDest, 12'h101);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();
    checkVal("full.head2", obsDest, 12'h102);
    stepCycle();
    checkVal("full.head3", obsDest, 12'h103);
    stepCycle();
    checkVal("full.head4", obsDest, 12'h1FF);
    checkVal("full.bothFlags", {obsRd, obsWr}, 2'b11);
    stepCycle();
    checkVal("full.empty", obsValid, 0);

    // Simultaneous push and pop keeps the count steady.
    resetCycle();
    clearFields();
    applyStimulus(1'b0, 4'b0010, 1'b0);
    setFields(1, 12'h0A0, 4'h1, 1'b1, 1'b0);
    stepCycle();
    setFields(1, 12'h0A1, 4'h3, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 4'b0010, 1'b1);
    setFields(1, 12'h0A2, 4'h5, 1'b0, 1'b0);
    stepCycle();
    checkVal("simul.countBefore", obsCount, 2);
    checkVal("simul.headBefore", obsDest, 12'h0A0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    stepCycle();
    checkVal("simul.countAfter", obsCount, 2);
    checkVal("simul.headAfter", obsDest, 12'h0A1);

    // Pointer wrap-around over ten headers.
    resetCycle();
    clearFields();
    applyStimulus(1'b0, 4'b0001, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) setFields(0, AW'(i), RW'(i), 1'b0, 1'b0);
      else requestIn = '0;
      stepCycle();
      if (i > 0) begin
        checkVal("wrap.valid", obsValid, 1);
        checkVal("wrap.dest", obsDest, i - 1);
      end
    end

    // Reset in the middle of traffic.
    resetCycle();
    applyStimulus(1'b0, 4'b1111, 1'b0);
    repeat (3) begin
      randomFields();
      stepCycle();
    end
    applyStimulus(1'b1, 4'b1111, 1'b0);
    stepCycle();
    checkVal("midReset.grant", obsGrant, 0);
    checkVal("midReset.countHeld", obsCount, 3);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    stepCycle();
    checkVal("midReset.count", obsCount, 0);
    checkVal("midReset.valid", obsValid, 0);
    checkVal("midReset.grantAfter", obsGrant, 4'b0001);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 49) == 0, N'($urandom), 1'($urandom));
      randomFields();
      stepCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
